// File: rtl/syn_forward_controller_pkg.sv
// Shared hazard/forwarding definitions: forward select encoding,
// load-flag bundle, default counter width and the forward select function.
package syn_forward_controller_pkg;

    localparam int CNT_WIDTH_DEF = 32;

    // 2'd3 is reserved and never produced.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_DM = 2'd2
    } fwd_e;

    typedef struct packed {
        logic ex_is_load;
        logic dm_is_load;
    } load_flags_t;

    // EX wins over DM because it holds the youngest writer. A load in EX
    // cannot forward (data not ready); that case is covered by the stall.
    function automatic fwd_e fwd_sel(
        input logic uses,
        input logic ex_col,
        input logic dm_col,
        input logic ex_ld
    );
        if (uses && ex_col && !ex_ld) begin
            return FWD_EX;
        end else if (uses && dm_col) begin
            return FWD_DM;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/syn_sat_counter.sv
// Saturating up-counter for performance events.
// Ports: clk, clear (sync, wins), inc, cnt[WIDTH-1:0].
module syn_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/syn_forward_controller.sv
// Hazard stage: turns detector collision flags into forward selects and a
// load-use stall, tracks in-flight loads and counts stall cycles.
// Ports: clk, rst (sync, active-high), en, ex/dm_collision_a/b, uses_a/b,
//        is_load -> stall, fwd_a, fwd_b, stall_cnt[CNT_WIDTH-1:0].
module syn_forward_controller
    import syn_forward_controller_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 ex_collision_a,
    input  logic                 dm_collision_a,
    input  logic                 ex_collision_b,
    input  logic                 dm_collision_b,
    input  logic                 uses_a,
    input  logic                 uses_b,
    input  logic                 is_load,
    output logic                 stall,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    load_flags_t flags;

    // A stall turns the EX slot into a bubble, so the stalled consumer
    // sees the load in DM next cycle and picks it up via FWD_DM.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (en) begin
            flags.ex_is_load <= stall ? 1'b0 : is_load;
            flags.dm_is_load <= flags.ex_is_load;
        end
    end

    always_comb begin
        stall = flags.ex_is_load &&
                ((uses_a && ex_collision_a) ||
                 (uses_b && ex_collision_b));
        fwd_a = fwd_sel(uses_a, ex_collision_a, dm_collision_a,
                        flags.ex_is_load);
        fwd_b = fwd_sel(uses_b, ex_collision_b, dm_collision_b,
                        flags.ex_is_load);
    end

    syn_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (en && stall),
        .cnt   (stall_cnt)
    );

    // dm_is_load is held for the future DM-to-EX load bypass; the load
    // that caused a stall must move into DM as the bubble enters EX.
    a_stall_moves_load: assert property (
        @(posedge clk) disable iff (rst)
        (!rst && en && stall) |=> (!flags.ex_is_load && flags.dm_is_load)
    );

endmodule
